// File: rtl/lcd_frame_capture.sv
// Shadow capture of the HD44780-style character bus into a 2x16 frame buffer.
// Build option: define LCD_FRAME_CAPTURE_CLEAR_EN to make 0x01 run a 32-cycle blanking clear.
module lcd_frame_capture #(
  parameter logic [7:0] BLANK_CHAR = 8'h20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RW_INPUT,
  input  logic       RS_INPUT,
  input  logic [7:0] DATA_INPUT,
  input  logic [4:0] RD_ADDR,
  output logic [7:0] RD_DATA,
  output logic [4:0] CUR_ADDR,
  output logic       BUSY,
  output logic       FRAME_DONE,
  output logic       BUS_ERR
);

  localparam int DEPTH = 32;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;
  logic [4:0] cur_addr_q, cur_addr_d;
  logic       frame_done_q, frame_done_d;
  logic       bus_err_q, bus_err_d;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       xfer, idle;
  logic       cmd_set, cmd_set_ok, cmd_home, cmd_clear;

  assign xfer       = ~RW_INPUT;
  assign cmd_set    = DATA_INPUT[7];
  assign cmd_set_ok = (DATA_INPUT[5:4] == 2'b00);
  assign cmd_home   = (DATA_INPUT[7:1] == 7'b0000001);
  assign cmd_clear  = (DATA_INPUT == 8'h01);

`ifdef LCD_FRAME_CAPTURE_CLEAR_EN
  typedef enum logic {S_IDLE, S_CLEAR} state_e;
  state_e     state_q;
  logic [4:0] clr_cnt_q;
  logic       busy_q;
  logic       clr_start;

  assign idle = (state_q == S_IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      clr_cnt_q <= 5'd0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clr_start) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= 5'd0;
            busy_q    <= 1'b1;
          end
        end
        S_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 5'd1;
          if (clr_cnt_q == 5'd31) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign BUSY = busy_q;
`else
  assign idle = 1'b1;
  assign BUSY = 1'b0;
`endif

  // Transfer decode; the clear sweep owns the write port while it runs.
  always_comb begin
    cur_addr_d   = cur_addr_q;
    frame_done_d = 1'b0;
    bus_err_d    = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = cur_addr_q;
    wr_data      = DATA_INPUT;
`ifdef LCD_FRAME_CAPTURE_CLEAR_EN
    clr_start    = 1'b0;
    if (!idle) begin
      wr_en   = 1'b1;
      wr_addr = clr_cnt_q;
      wr_data = BLANK_CHAR;
    end
`endif
    if (xfer) begin
      if (!idle) begin
        bus_err_d = 1'b1;
      end else if (RS_INPUT) begin
        wr_en        = 1'b1;
        cur_addr_d   = cur_addr_q + 5'd1;
        frame_done_d = (cur_addr_q == 5'd31);
      end else if (cmd_set) begin
        if (cmd_set_ok) cur_addr_d = {DATA_INPUT[6], DATA_INPUT[3:0]};
        else            bus_err_d  = 1'b1;
      end else if (cmd_home || cmd_clear) begin
        cur_addr_d = 5'd0;
`ifdef LCD_FRAME_CAPTURE_CLEAR_EN
        clr_start  = cmd_clear;
`endif
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cur_addr_q   <= 5'd0;
      frame_done_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      cur_addr_q   <= cur_addr_d;
      frame_done_q <= frame_done_d;
      bus_err_q    <= bus_err_d;
    end
  end

  // Read sees the pre-write contents when addresses collide.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= BLANK_CHAR;
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= mem_q[RD_ADDR];
      if (wr_en) mem_q[wr_addr] <= wr_data;
    end
  end

  assign RD_DATA    = rd_data_q;
  assign CUR_ADDR   = cur_addr_q;
  assign FRAME_DONE = frame_done_q;
  assign BUS_ERR    = bus_err_q;

endmodule

// File: tb/tb_lcd_frame_capture.sv
// Directed and random checks of lcd_frame_capture against a transfer-level frame buffer model.
module tb_lcd_frame_capture;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       RW_INPUT = 1'b1;
  logic       RS_INPUT = 1'b0;
  logic [7:0] DATA_INPUT = 8'h00;
  logic [4:0] RD_ADDR = 5'd0;
  logic [7:0] RD_DATA;
  logic [4:0] CUR_ADDR;
  logic       BUSY, FRAME_DONE, BUS_ERR;

  lcd_frame_capture #(.BLANK_CHAR(8'h20)) dut (
    .CLK(CLK), .RESET(RESET), .RW_INPUT(RW_INPUT), .RS_INPUT(RS_INPUT),
    .DATA_INPUT(DATA_INPUT), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA),
    .CUR_ADDR(CUR_ADDR), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .BUS_ERR(BUS_ERR)
  );

  always #5 CLK = ~CLK;

`ifdef LCD_FRAME_CAPTURE_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  logic [7:0] mem_m [32];
  int cur_m = 0;
  int clr_left = 0;
  logic exp_err, exp_fd;
  int busy_obs, err_obs, fd_obs;

  function automatic void chk(string tag, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endfunction

  // Effect of one bus cycle on the frame, expressed as the panel's command semantics.
  task automatic model(input logic rw, input logic rs, input logic [7:0] d);
    exp_err = 1'b0;
    exp_fd  = 1'b0;
    if (clr_left > 0) begin
      mem_m[32 - clr_left] = 8'h20;
      clr_left--;
      if (!rw) exp_err = 1'b1;
    end else if (!rw) begin
      if (rs) begin
        mem_m[cur_m] = d;
        exp_fd = (cur_m == 31);
        cur_m = (cur_m + 1) % 32;
      end else if (d >= 8'h80) begin
        if ((d & 8'h30) == 8'h00) cur_m = ((d & 8'h40) != 0 ? 16 : 0) + int'(d & 8'h0F);
        else exp_err = 1'b1;
      end else if (d == 8'h02 || d == 8'h03) begin
        cur_m = 0;
      end else if (d == 8'h01) begin
        cur_m = 0;
        if (CLR_EN) clr_left = 32;
      end
    end
  endtask

  task automatic step(input logic rw, input logic rs, input logic [7:0] d, input logic [4:0] ra);
    logic [7:0] exp_rd;
    RW_INPUT = rw; RS_INPUT = rs; DATA_INPUT = d; RD_ADDR = ra;
    exp_rd = mem_m[ra];
    model(rw, rs, d);
    @(posedge CLK); #1;
    if (BUSY === 1'b1) busy_obs++;
    if (BUS_ERR === 1'b1) err_obs++;
    if (FRAME_DONE === 1'b1) fd_obs++;
    chk("rd_data", RD_DATA, exp_rd);
    chk("cur_addr", {3'b0, CUR_ADDR}, 8'(cur_m));
    chk("bus_err", {7'b0, BUS_ERR}, {7'b0, exp_err});
    chk("frame_done", {7'b0, FRAME_DONE}, {7'b0, exp_fd});
    chk("busy", {7'b0, BUSY}, {7'b0, clr_left > 0});
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    RW_INPUT = 1'b0; RS_INPUT = 1'b1; DATA_INPUT = 8'h55; RD_ADDR = 5'd3;
    @(posedge CLK); #1;
    for (int i = 0; i < 32; i++) mem_m[i] = 8'h20;
    cur_m = 0; clr_left = 0;
    chk("rst_rd_data", RD_DATA, 8'h00);
    chk("rst_cur_addr", {3'b0, CUR_ADDR}, 8'h00);
    chk("rst_busy", {7'b0, BUSY}, 8'h00);
    chk("rst_frame_done", {7'b0, FRAME_DONE}, 8'h00);
    chk("rst_bus_err", {7'b0, BUS_ERR}, 8'h00);
    RESET = 1'b0; RW_INPUT = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 5'($urandom));
  endtask

  task automatic sweep();
    for (int a = 0; a < 32; a++) step(1'b1, 1'b0, 8'h00, 5'(a));
  endtask

  task automatic cmd(input logic [7:0] d);  step(1'b0, 1'b0, d, 5'($urandom)); endtask
  task automatic dat(input logic [7:0] d);  step(1'b0, 1'b1, d, 5'($urandom)); endtask

  task automatic read_const(input logic [4:0] a, input logic [7:0] v, input string tag);
    step(1'b1, 1'b0, 8'h00, a);
    chk(tag, RD_DATA, v);
  endtask

  initial begin
    string s1, s2;
    logic [7:0] d;
    logic rw, rs;
    s1 = "Today is        ";
    s2 = "     2020-01-01 ";

    do_reset();
    sweep();
    read_const(5'd0, 8'h20, "blank0");
    read_const(5'd31, 8'h20, "blank31");

    // Two-line message; frame completes on the last column of line 2.
    fd_obs = 0;
    cmd(8'h80);
    for (int i = 0; i < 16; i++) dat(s1[i]);
    cmd(8'hC0);
    for (int i = 0; i < 16; i++) dat(s2[i]);
    chk("fd_count", 8'(fd_obs), 8'd1);
    chk("cur_wrap", {3'b0, CUR_ADDR}, 8'h00);
    idle(1);
    sweep();
    read_const(5'd0, 8'h54, "buf0_T");
    read_const(5'd7, 8'h73, "buf7_s");
    read_const(5'd21, 8'h32, "buf21_2");
    read_const(5'd30, 8'h31, "buf30_1");

    // Line-1 end rolls into line 2.
    cmd(8'h8F);
    dat(8'h19);
    dat(8'h41);
    chk("cur_17", {3'b0, CUR_ADDR}, 8'd17);
    read_const(5'd15, 8'h19, "buf15");
    read_const(5'd16, 8'h41, "buf16");

    // Illegal address command, then return home.
    err_obs = 0;
    cmd(8'hB0);
    idle(2);
    chk("err_count", 8'(err_obs), 8'd1);
    chk("cur_kept", {3'b0, CUR_ADDR}, 8'd17);
    cmd(8'h02);
    chk("cur_home", {3'b0, CUR_ADDR}, 8'd0);

    // Fill, clear, and a transfer lost five cycles into the clear.
    cmd(8'h80);
    for (int i = 0; i < 32; i++) dat(8'h41);
    busy_obs = 0; err_obs = 0;
    cmd(8'h01);
    idle(4);
    dat(8'h42);
    idle(40);
    chk("busy_cycles", 8'(busy_obs), CLR_EN ? 8'd32 : 8'd0);
    chk("clr_err_count", 8'(err_obs), CLR_EN ? 8'd1 : 8'd0);
    sweep();
    read_const(5'd0, CLR_EN ? 8'h20 : 8'h42, "clr_buf0");
    read_const(5'd9, CLR_EN ? 8'h20 : 8'h41, "clr_buf9");

    // Reset part way through a clear.
    cmd(8'h80);
    for (int i = 0; i < 32; i++) dat(8'h41);
    cmd(8'h01);
    idle(10);
    do_reset();
    sweep();

    // Random traffic, mostly commands from the meaningful set.
    for (int n = 0; n < 400; n++) begin
      rw = ($urandom_range(0, 3) == 0);
      rs = $urandom_range(0, 1) == 1;
      d  = 8'($urandom);
      if (!rs) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: d = d | 8'h80;
          4:          d = 8'h02;
          5:          d = 8'h03;
          6:          d = ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h02;
          default:    d = d & 8'h7F;
        endcase
      end
      step(rw, rs, d, 5'($urandom));
    end
    idle(40);
    sweep();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
